// File: rtl/player_hit_check.sv
`default_nettype none
// ============================================================================
// Module  : player_hit_check
// Purpose : per-tick bullet table scan vs. player hitbox; HP, i-frames, death
// Revision: 1.0
// ============================================================================
module player_hit_check #(
  parameter int NUM_BULLETS  = 64,
  parameter int TICK_CYCLES  = 1666667,
  parameter int HP_INIT      = 5,
  parameter int INVULN_TICKS = 120,
  parameter int HITBOX_R     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     state,
  input  logic [6:0]                     player_x,
  input  logic [6:0]                     player_y,
  output logic [$clog2(NUM_BULLETS)-1:0] bullet_addr,
  input  logic                           bullet_valid,
  input  logic [6:0]                     bullet_x,
  input  logic [6:0]                     bullet_y,
  output logic                           hit,
  output logic [2:0]                     hp,
  output logic                           invulnerable,
  output logic                           player_dead,
  output logic                           scan_busy
);

  localparam int AW = $clog2(NUM_BULLETS);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int IW = $clog2(INVULN_TICKS + 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SCAN    = 2'd1;
  localparam logic [1:0] c_RESOLVE = 2'd2;

  localparam logic [TW-1:0]     c_TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0]     c_ADDR_LAST = AW'(NUM_BULLETS - 1);
  localparam logic [IW-1:0]     c_INV_LOAD  = IW'(INVULN_TICKS);
  localparam logic [2:0]        c_HP_INIT   = 3'(HP_INIT);
  localparam logic signed [7:0] c_R         = 8'(HITBOX_R);

  logic [1:0]        r_fsm;
  logic [1:0]        w_fsm_next;
  logic              r_prev_play;
  logic [TW-1:0]     r_tick_cnt;
  logic [IW-1:0]     r_inv_cnt;
  logic [IW-1:0]     w_inv_next;
  logic [6:0]        r_px;
  logic [6:0]        r_py;
  logic              r_hit_found;
  logic              r_last_issued;
  logic              r_beat_vld;
  logic              w_play;
  logic              w_entry;
  logic              w_tick;
  logic              w_near;
  logic              w_apply;
  logic signed [7:0] w_dx;
  logic signed [7:0] w_dy;

  assign w_play  = (state == 4'd2);
  assign w_entry = w_play && !r_prev_play;
  assign w_tick  = w_play && (r_tick_cnt == c_TICK_LAST);

  assign w_dx   = $signed({1'b0, bullet_x}) - $signed({1'b0, r_px});
  assign w_dy   = $signed({1'b0, bullet_y}) - $signed({1'b0, r_py});
  assign w_near = bullet_valid && (w_dx >= -c_R) && (w_dx <= c_R)
                               && (w_dy >= -c_R) && (w_dy <= c_R);

  assign w_apply = (r_fsm == c_RESOLVE) && w_play && r_hit_found
                   && (r_inv_cnt == '0) && (hp != 3'd0);

  // The counter sits at 0 outside play, so play entry always restarts from 0.
  always_ff @(posedge clk) begin
    if (rst || !w_play) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_play <= 1'b0;
    end else begin
      r_prev_play <= w_play;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= c_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_fsm_next = r_fsm;
    if (!w_play) begin
      w_fsm_next = c_IDLE;
    end else begin
      case (r_fsm)
        c_IDLE:    if (w_tick && !player_dead) w_fsm_next = c_SCAN;
        c_SCAN:    if (r_last_issued) w_fsm_next = c_RESOLVE;
        c_RESOLVE: w_fsm_next = c_IDLE;
        default:   w_fsm_next = c_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    scan_busy = (r_fsm != c_IDLE);
  end

  // Read data trails the address by one cycle; r_beat_vld marks returned beats.
  always_ff @(posedge clk) begin
    if (rst || !w_play) begin
      bullet_addr   <= '0;
      r_last_issued <= 1'b0;
      r_beat_vld    <= 1'b0;
      r_hit_found   <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
    end else begin
      case (r_fsm)
        c_IDLE: begin
          bullet_addr   <= '0;
          r_last_issued <= 1'b0;
          r_beat_vld    <= 1'b0;
          if (w_fsm_next == c_SCAN) begin
            r_px        <= player_x;
            r_py        <= player_y;
            r_hit_found <= 1'b0;
          end
        end
        c_SCAN: begin
          r_beat_vld <= !r_last_issued;
          if (!r_last_issued) begin
            if (bullet_addr == c_ADDR_LAST) begin
              r_last_issued <= 1'b1;
            end else begin
              bullet_addr <= bullet_addr + AW'(1);
            end
          end
          if (r_beat_vld && w_near) begin
            r_hit_found <= 1'b1;
          end
        end
        default: begin
          bullet_addr   <= '0;
          r_last_issued <= 1'b0;
          r_beat_vld    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_inv_next = r_inv_cnt;
    if (w_entry) begin
      w_inv_next = '0;
    end else if (w_apply) begin
      w_inv_next = c_INV_LOAD;
    end else if (w_tick && (r_inv_cnt != '0)) begin
      w_inv_next = r_inv_cnt - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp           <= c_HP_INIT;
      player_dead  <= 1'b0;
      hit          <= 1'b0;
      r_inv_cnt    <= '0;
      invulnerable <= 1'b0;
    end else begin
      hit          <= w_apply;
      r_inv_cnt    <= w_inv_next;
      invulnerable <= (w_inv_next != '0);
      if (w_entry) begin
        hp          <= c_HP_INIT;
        player_dead <= 1'b0;
      end else if (w_apply) begin
        hp <= hp - 3'd1;
        if (hp == 3'd1) begin
          player_dead <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
